// File: rtl/instruction_fetch_queue.sv
// Instruction-fetch stage: loader-written program memory, sequential prefetch into a small queue, redirect flush.
// Optional halt-word detection is compiled in with `define IF_HALT_DETECT_EN.
module instruction_fetch_queue #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              i_PCWrite,
  input  logic              i_PCSrc,
  input  logic [PC_W-1:0]   i_PCBranch,
  input  logic              i_write_inst_mem,
  input  logic [PC_W-1:0]   i_inst_mem_addr,
  input  logic [DATA_W-1:0] i_inst_mem_data,
  output logic [PC_W-1:0]   o_PCNext,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_valid,
  output logic              o_halt
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam logic [QW:0] QD_FULL = (QW+1)'(QUEUE_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [PC_W-1:0]   rd_pc;

  logic [DATA_W-1:0] q_data [QUEUE_DEPTH];
  logic [PC_W-1:0]   q_pcn  [QUEUE_DEPTH];
  logic [QW-1:0]     head, tail;
  logic [QW:0]       count;
  logic [QW:0]       occupancy;
  logic              inflight;
  logic [PC_W-1:0]   f_pc;

  logic redirect, push, pop, issue;
  logic halted, halt_push;

  // Occupancy reserves a slot for the read in flight so a full queue never overflows.
  assign occupancy = count + {{QW{1'b0}}, inflight};
  assign redirect  = enable & i_PCSrc;
  assign push      = enable & inflight & ~i_PCSrc;
  assign pop       = enable & i_PCWrite & o_valid & ~i_PCSrc;
  assign issue     = enable & ~i_write_inst_mem & ~i_PCSrc & (occupancy < QD_FULL)
                   & ~halted & ~halt_push;

`ifdef IF_HALT_DETECT_EN
  assign halt_push = push & (rd_data == '1);

  always_ff @(posedge clk) begin
    if (rst || redirect) halted <= 1'b0;
    else if (halt_push)  halted <= 1'b1;
  end
`else
  assign halt_push = 1'b0;
  assign halted    = 1'b0;
`endif

  // Single-port memory: issue is already blocked on loader-write cycles.
  always_ff @(posedge clk) begin
    if (i_write_inst_mem) mem[i_inst_mem_addr[AW-1:0]] <= i_inst_mem_data;
    if (issue) begin
      rd_data <= mem[f_pc[AW-1:0]];
      rd_pc   <= f_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= rd_data;
      q_pcn[tail]  <= rd_pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc     <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      f_pc     <= i_PCBranch;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (enable) begin
      inflight <= issue;
      if (issue) f_pc <= f_pc + 1'b1;
      if (push)  tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_valid       = (count != '0);
  assign o_instruction = o_valid ? q_data[head] : '0;
  assign o_PCNext      = o_valid ? q_pcn[head]  : '0;
`ifdef IF_HALT_DETECT_EN
  assign o_halt        = o_valid & (q_data[head] == '1);
`else
  assign o_halt        = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_inst_mem_addr, f_pc};

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: vector table for fetch/stall/redirect/enable/reset, plus a halt sequence.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, enable, i_PCWrite, i_PCSrc, i_write_inst_mem;
  logic [31:0] i_PCBranch, i_inst_mem_addr, i_inst_mem_data;
  logic [31:0] o_PCNext, o_instruction;
  logic        o_valid, o_halt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .DATA_W(32), .PC_W(32), .MEM_DEPTH(256), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .i_PCWrite(i_PCWrite), .i_PCSrc(i_PCSrc),
    .i_PCBranch(i_PCBranch), .i_write_inst_mem(i_write_inst_mem),
    .i_inst_mem_addr(i_inst_mem_addr), .i_inst_mem_data(i_inst_mem_data),
    .o_PCNext(o_PCNext), .o_instruction(o_instruction), .o_valid(o_valid), .o_halt(o_halt)
  );

  typedef struct {
    logic        rst, en, pw, src;
    logic [31:0] br;
    logic        v;
    logic [31:0] inst, pcn;
  } vec_t;

  vec_t vq[$];

`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  task automatic add(input logic r, input logic en, input logic pw, input logic src,
                     input logic [31:0] br, input logic v, input logic [31:0] inst,
                     input logic [31:0] pcn);
    vec_t t;
    t.rst = r; t.en = en; t.pw = pw; t.src = src; t.br = br;
    t.v = v; t.inst = inst; t.pcn = pcn;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] pcn, input logic halt);
    check({tag, ".valid"}, {31'b0, o_valid}, {31'b0, v});
    check({tag, ".inst"},  o_instruction, inst);
    check({tag, ".pcnext"}, o_PCNext, pcn);
    check({tag, ".halt"},  {31'b0, o_halt}, {31'b0, halt});
  endtask

  task automatic drive(input logic r, input logic en, input logic pw, input logic src,
                       input logic [31:0] br);
    rst = r; enable = en; i_PCWrite = pw; i_PCSrc = src; i_PCBranch = br;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    i_write_inst_mem = 1'b1; i_inst_mem_addr = addr; i_inst_mem_data = data;
    tick();
    i_write_inst_mem = 1'b0;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    i_write_inst_mem = 1'b0; i_inst_mem_addr = '0; i_inst_mem_data = '0;
    tick(); tick();
    check_out("reset", 1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) load(i, 32'(10 * (i + 1)));
    check_out("after_load", 1'b0, 32'd0, 32'd0, 1'b0);

    // fetch start and first instruction
    add(0,1,1,0,0, 0, 0, 0);
    add(0,1,1,0,0, 1,10, 1);
    // decode stall: queue fills, head holds
    for (int i = 0; i < 6; i++) add(0,1,0,0,0, 1,10,1);
    add(0,1,1,0,0, 1,20,2);
    add(0,1,1,0,0, 1,30,3);
    add(0,1,1,0,0, 1,40,4);
    add(0,1,1,0,0, 1,50,5);
    add(0,1,0,0,0, 1,50,5);
    // redirect to 1 with 3 entries queued
    add(0,1,1,1,1, 0, 0, 0);
    add(0,1,1,0,0, 0, 0, 0);
    add(0,1,1,0,0, 1,20,2);
    add(0,1,1,0,0, 1,30,3);
    // enable low with a read in flight
    for (int i = 0; i < 3; i++) add(0,0,1,0,0, 1,30,3);
    add(0,1,1,0,0, 1,40,4);
    add(0,1,1,0,0, 1,50,5);
    // fill the queue, then reset
    for (int i = 0; i < 3; i++) add(0,1,0,0,0, 1,50,5);
    add(1,1,1,0,0, 0, 0, 0);
    add(0,1,1,0,0, 0, 0, 0);
    add(0,1,1,0,0, 1,10,1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].pw, vq[i].src, vq[i].br);
      tick();
      check_out($sformatf("vec%0d", i), vq[i].v, vq[i].inst, vq[i].pcn, 1'b0);
    end

    // halt word at address 3
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    load(32'd3, 32'hFFFF_FFFF);
    enable = 1'b1;
    tick(); check_out("halt_e1", 1'b0, 32'd0, 32'd0, 1'b0);
    tick(); check_out("halt_e2", 1'b1, 32'd10, 32'd1, 1'b0);
    tick(); check_out("halt_e3", 1'b1, 32'd20, 32'd2, 1'b0);
    tick(); check_out("halt_e4", 1'b1, 32'd30, 32'd3, 1'b0);
    tick(); check_out("halt_head", 1'b1, 32'hFFFF_FFFF, 32'd4, HALT_ON);
    tick();
    if (HALT_ON) check_out("halt_pop", 1'b0, 32'd0, 32'd0, 1'b0);
    else         check_out("halt_pop", 1'b1, 32'd50, 32'd5, 1'b0);
    tick();
    if (HALT_ON) check_out("halt_stopped", 1'b0, 32'd0, 32'd0, 1'b0);
    else         check_out("halt_stopped", 1'b1, 32'd60, 32'd6, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
    tick(); check_out("halt_redir", 1'b0, 32'd0, 32'd0, 1'b0);
    i_PCSrc = 1'b0;
    tick(); check_out("halt_redir1", 1'b0, 32'd0, 32'd0, 1'b0);
    tick(); check_out("halt_resume", 1'b1, 32'd10, 32'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
